// File: rtl/ofdm_symbol_scheduler.sv
// Symbol-granular arbiter feeding the CP adder's Avalon-ST sink from preamble or payload sources.
// Optional inter-symbol idle gap enabled by defining OFDM_SCHED_GAP_EN.
module ofdm_symbol_scheduler #(
  parameter int unsigned DW      = 22,
  parameter int unsigned N_FFT   = 64,
  parameter int unsigned CW      = 10,
  parameter int unsigned MAX_PRE = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [DW-1:0] pre_data,
  input  logic          pre_valid,
  output logic          pre_ready,
  input  logic [DW-1:0] pay_data,
  input  logic          pay_valid,
  output logic          pay_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic          grant_pre,
  output logic [15:0]   sym_count
);

  localparam int unsigned RW = (MAX_PRE > 1) ? $clog2(MAX_PRE + 1) : 1;

  typedef enum logic [1:0] {
    StArb,
    StXfer,
    StGap
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [RW-1:0] pre_run_q, pre_run_d;
  logic          grant_pre_q, grant_pre_d;
  logic [15:0]   sym_count_q;
  logic          beat, last_beat;

`ifdef OFDM_SCHED_GAP_EN
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  logic [GW-1:0] gap_q, gap_d;
`else
  logic unused_gap_cyc;
  assign unused_gap_cyc = ^GAP_CYC;
`endif

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    pre_run_d    = pre_run_q;
    grant_pre_d  = grant_pre_q;
    pre_ready    = 1'b0;
    pay_ready    = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    beat         = 1'b0;
    last_beat    = 1'b0;
`ifdef OFDM_SCHED_GAP_EN
    gap_d        = gap_q;
`endif
    unique case (state_q)
      StArb: begin
        // Preamble wins ties until it has held MAX_PRE symbols in a row.
        if (pre_valid && (!pay_valid || (pre_run_q < RW'(MAX_PRE)))) begin
          grant_pre_d = 1'b1;
          state_d     = StXfer;
          if (pre_run_q != RW'(MAX_PRE)) pre_run_d = pre_run_q + 1'b1;
        end else if (pay_valid) begin
          grant_pre_d = 1'b0;
          pre_run_d   = '0;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        out_valid = grant_pre_q ? pre_valid : pay_valid;
        out_data  = grant_pre_q ? pre_data : pay_data;
        pre_ready = grant_pre_q & out_ready;
        pay_ready = ~grant_pre_q & out_ready;
        out_sop   = out_valid && (sample_cnt_q == '0);
        out_eop   = out_valid && (sample_cnt_q == CW'(N_FFT - 1));
        beat      = out_valid & out_ready;
        last_beat = beat && (sample_cnt_q == CW'(N_FFT - 1));
        if (beat) sample_cnt_d = last_beat ? '0 : sample_cnt_q + 1'b1;
        if (last_beat) begin
`ifdef OFDM_SCHED_GAP_EN
          if (GAP_CYC != 0) begin
            state_d = StGap;
            gap_d   = GW'(GAP_CYC);
          end else begin
            state_d = StArb;
          end
`else
          state_d = StArb;
`endif
        end
      end
`ifdef OFDM_SCHED_GAP_EN
      StGap: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = StArb;
      end
`endif
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= StArb;
      sample_cnt_q <= '0;
      pre_run_q    <= '0;
      grant_pre_q  <= 1'b0;
      sym_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      pre_run_q    <= pre_run_d;
      grant_pre_q  <= grant_pre_d;
      if (last_beat) sym_count_q <= sym_count_q + 16'd1;
    end
  end

`ifdef OFDM_SCHED_GAP_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign grant_pre = grant_pre_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Randomized scoreboard bench for ofdm_symbol_scheduler; a symbol-level reference model
// predicts grants and per-beat data, a separate monitor pops and compares each output beat.
module tb_ofdm_symbol_scheduler;

  localparam int unsigned DW   = 22;
  localparam int unsigned N    = 64;
  localparam int unsigned CW   = 10;
  localparam int unsigned MAXP = 4;
  localparam int unsigned GAPC = 2;
`ifdef OFDM_SCHED_GAP_EN
  localparam int GAP = GAPC;
`else
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_reset_n;
  logic [DW-1:0] pre_data, pay_data, out_data;
  logic          pre_valid, pre_ready, pay_valid, pay_ready;
  logic          out_valid, out_ready, out_sop, out_eop, grant_pre;
  logic [15:0]   sym_count;

  always #5 clk = ~clk;

  ofdm_symbol_scheduler #(
    .DW     (DW),
    .N_FFT  (N),
    .CW     (CW),
    .MAX_PRE(MAXP),
    .GAP_CYC(GAPC)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(reset_reset_n),
    .pre_data     (pre_data),
    .pre_valid    (pre_valid),
    .pre_ready    (pre_ready),
    .pay_data     (pay_data),
    .pay_valid    (pay_valid),
    .pay_ready    (pay_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .grant_pre    (grant_pre),
    .sym_count    (sym_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          gp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  logic [15:0] mon_syms = '0;
  int          cyc = 0;
  int          last_eop = -1;
  bit          gap_chk = 0;
  bit          t3_rec = 0;
  logic        t3_got[$];

  // Stimulus and model state
  int mode = 0;
  int pre_idx = 0, pay_idx = 0;
  int m_pre_base = 0, m_pay_base = 0;
  bit m_in_sym = 0, m_gp = 0;
  int m_left = 0, m_gap = 0, m_run = 0, m_done = 0;
  int drop_left = 0;
  bit drop_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tag(input logic t, input int idx);
    logic [DW-2:0] v;
    v = idx[DW-2:0];
    return {t, v};
  endfunction

  task automatic drive();
    case (mode)
      1: begin
        pre_valid = ($urandom_range(0, 3) != 0);
        pay_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      2: begin
        pre_valid = 1'b1; pay_valid = 1'b1; out_ready = 1'b1;
      end
      3: begin
        pre_valid = 1'b0; pay_valid = 1'b1; out_ready = 1'b1;
      end
      4: begin
        pre_valid = 1'b0;
        out_ready = ~out_ready;
        if (drop_left > 0) begin
          pay_valid = 1'b0;
          drop_left--;
          if (drop_left == 0) drop_done = 1;
        end else if (!drop_done && (pay_idx % N == 20)) begin
          pay_valid = 1'b0;
          drop_left = 4;
        end else begin
          pay_valid = 1'b1;
        end
      end
      default: begin
        pre_valid = 1'b0; pay_valid = 1'b0; out_ready = 1'b1;
      end
    endcase
    pre_data = tag(1'b1, pre_idx);
    pay_data = tag(1'b0, pay_idx);
  endtask

  task automatic set_mode(input int m);
    mode = m;
    drive();
  endtask

  // A grant queues the whole symbol: N consecutive samples of the chosen stream.
  task automatic grant(input bit gp);
    exp_t x;
    for (int k = 0; k < int'(N); k++) begin
      x.data = gp ? tag(1'b1, m_pre_base + k) : tag(1'b0, m_pay_base + k);
      x.sop  = (k == 0);
      x.eop  = (k == int'(N) - 1);
      x.gp   = gp;
      sb.push_back(x);
    end
    if (gp) m_pre_base += N;
    else m_pay_base += N;
    m_in_sym = 1;
    m_gp     = gp;
    m_left   = N;
  endtask

  task automatic step();
    bit ev;
    @(negedge clk);
    if (m_in_sym) begin
      ev = m_gp ? pre_valid : pay_valid;
      check("out_valid", 32'(out_valid), 32'(ev));
      check("pre_ready", 32'(pre_ready), 32'(m_gp & out_ready));
      check("pay_ready", 32'(pay_ready), 32'(!m_gp & out_ready));
      if (ev && out_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_in_sym = 0;
          m_gap    = GAP;
          m_done++;
        end
      end
    end else begin
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_pre_ready", 32'(pre_ready), 0);
      check("idle_pay_ready", 32'(pay_ready), 0);
      if (m_gap > 0) begin
        m_gap--;
      end else if (pre_valid && (!pay_valid || m_run < int'(MAXP))) begin
        grant(1'b1);
        if (m_run < int'(MAXP)) m_run++;
      end else if (pay_valid) begin
        grant(1'b0);
        m_run = 0;
      end
    end
    if (pre_valid && pre_ready) pre_idx++;
    if (pay_valid && pay_ready) pay_idx++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_syms(input int m, input int k);
    int target;
    int budget;
    target = m_done + k;
    budget = 0;
    set_mode(m);
    while (!(m_done >= target && !m_in_sym && m_gap == 0) && budget < 5000) begin
      step();
      budget++;
    end
    if (budget >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL symbol_timeout actual=%0d expected=%0d", m_done, target);
    end
    set_mode(0);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_pre_ready", 32'(pre_ready), 0);
    check("rst_pay_ready", 32'(pay_ready), 0);
    check("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_grant_pre", 32'(grant_pre), 0);
    check("rst_sym_count", 32'(sym_count), 0);
    mon_en = 0;
    sb.delete();
    mon_syms = '0;
    pre_idx = 0; pay_idx = 0; m_pre_base = 0; m_pay_base = 0;
    m_in_sym = 0; m_gap = 0; m_run = 0;
    set_mode(0);
    repeat (2) @(posedge clk);
    #1;
    reset_reset_n = 1'b1;
    mon_en = 1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && reset_reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected actual=%0h expected=no_beat", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sop", 32'(out_sop), 32'(e.sop));
        check("out_eop", 32'(out_eop), 32'(e.eop));
        check("grant_pre", 32'(grant_pre), 32'(e.gp));
        check("sym_count", 32'(sym_count), 32'(mon_syms));
        if (gap_chk && e.sop && last_eop >= 0) check("eop_to_sop", cyc - last_eop, GAP + 2);
        if (e.eop) begin
          mon_syms = mon_syms + 16'd1;
          last_eop = cyc;
        end
        if (t3_rec && e.sop) t3_got.push_back(grant_pre);
      end
    end
  end

  initial begin
    logic exp_seq [10];
    int   budget;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset_reset_n = 1'b1;
    set_mode(0);
    #2;
    do_reset();

    // Continuous payload, with inter-symbol spacing measured
    gap_chk  = 1;
    last_eop = -1;
    run_syms(3, 3);
    gap_chk = 0;
    step();
    check("t2_sym_count", 32'(sym_count), 3);

    // Reset in the middle of a payload symbol
    set_mode(3);
    budget = 0;
    while (!(m_in_sym && m_left == int'(N) / 2) && budget < 200) begin
      step();
      budget++;
    end
    check("t1_reached_mid_symbol", 32'(budget < 200), 1);
    do_reset();

    // Both sources always valid: anti-starvation grant pattern
    t3_rec = 1;
    run_syms(2, 10);
    t3_rec = 0;
    check("t3_grant_count", t3_got.size(), 10);
    for (int i = 0; i < 10 && i < t3_got.size(); i++) check("t3_grant_seq", 32'(t3_got[i]), 32'(exp_seq[i]));

    // Toggling backpressure with a payload valid dropout at sample 20
    out_ready = 1'b1;
    drop_done = 0;
    drop_left = 0;
    run_syms(4, 1);
    check("t4_drop_seen", 32'(drop_done), 1);

    // Randomized valids and backpressure
    run_syms(1, 12);
    repeat (3) step();

    // Symbol counter wrap
    force dut.sym_count_q = 16'hFFFF;
    #1;
    release dut.sym_count_q;
    mon_syms = 16'hFFFF;
    run_syms(3, 1);
    step();
    check("t6_wrap", 32'(sym_count), 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
